// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit for the EX stage. Handles signed and
//   unsigned MULT/DIV and returns a double-width {hi, lo} result for the HI/LO
//   writeback path. The multiplier completes after MULT_LATENCY cycles. The
//   divider is an iterative radix-2 restoring FSM: WIDTH iterations followed by
//   a FIX cycle.
//
//   Handshake (start/busy/done):
//     - A request is accepted on a rising edge where start && !busy && !flush.
//       op and both operands are captured on that edge, and busy is high from
//       the next cycle.
//     - done is a single-cycle pulse. result is written on the same edge that
//       raises done and then holds until the next done or reset.
//     - busy falls in the cycle where done rises. start is ignored while busy
//       is high and is never queued.
//     - flush wins over start. It returns the FSM to IDLE on the next edge,
//       and the aborted operation never produces done.
//
//   Configuration macro:
//     MDU_DIVZERO_FAST_EN  When defined, DIV/DIVU with operand_2 == 0 skips
//                          the iterations. It goes IDLE -> FIX -> IDLE, and
//                          done rises one cycle after accept.
//                          When undefined, divide by zero runs the full
//                          WIDTH+1 cycles. The result is identical.
//
//   Ports:
//     clk        clock, all state on rising edge
//     rst        asynchronous active-low reset
//     flush      abort the current operation
//     start      request, qualified by !busy && !flush
//     op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     operand_1  multiplicand / dividend
//     operand_2  multiplier / divisor
//     busy       operation in flight
//     done       one-cycle completion pulse
//     result     MULT: full product; DIV: {remainder, quotient}
//     dbg_state  current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH        = 32,
   parameter int MULT_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     operand_1,
   input  logic [WIDTH-1:0]     operand_2,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam int CNT_MAX = (WIDTH > MULT_LATENCY) ? WIDTH : MULT_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // The counter starts at 0 in the first busy cycle.
   // MUL stays busy for MULT_LATENCY-1 cycles. DIV runs WIDTH iterations.
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] MUL_LAST = CW'((MULT_LATENCY >= 2) ? (MULT_LATENCY - 2) : 0);

   state_t                state, state_n;
   logic [CW-1:0]         cnt;

   // Working registers. For MUL, quo_q and dvs_q hold the two magnitudes.
   // For DIV, quo_q starts as the dividend magnitude and becomes the quotient.
   logic [WIDTH-1:0]      quo_q;
   logic [WIDTH-1:0]      rem_q;
   logic [WIDTH-1:0]      dvs_q;
   logic [WIDTH-1:0]      op1_q;      // raw dividend, used for the divide-by-zero result
   logic                  neg_q;      // negate product / quotient
   logic                  rneg_q;     // negate remainder (dividend was negative)
   logic                  dz_q;       // divisor was zero

   logic [2*WIDTH-1:0]    result_q;
   logic                  done_q;

   // Combinational control and datapath
   logic                  accept;
   logic                  wr_res;
   logic [2*WIDTH-1:0]    res_n;

   logic                  in_sgn;
   logic                  in_neg;
   logic [WIDTH-1:0]      in_mag1;
   logic [WIDTH-1:0]      in_mag2;

   logic [WIDTH:0]        shifted;
   logic [WIDTH-1:0]      diff;
   logic                  ge;
   logic [WIDTH-1:0]      it_rem;
   logic [WIDTH-1:0]      it_quo;
   logic [WIDTH-1:0]      q_fix;
   logic [WIDTH-1:0]      r_fix;
   logic [2*WIDTH-1:0]    div_res;

   logic [2*WIDTH-1:0]    prod_mag;
   logic [2*WIDTH-1:0]    prod;
   logic [2*WIDTH-1:0]    in_prod_mag;
   logic [2*WIDTH-1:0]    in_prod;

   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign accept    = start && !busy && !flush;
   assign done      = done_q;
   assign result    = result_q;
   assign dbg_state = state;

   // Convert the operands to magnitudes. The core below is always unsigned.
   always_comb begin
      in_sgn  = ~op[0];
      in_mag1 = (in_sgn && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
      in_mag2 = (in_sgn && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
      in_neg  = in_sgn && (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
   end

   // Multiplier. The sign is applied on the edge that writes the result.
   // in_prod is used only when MULT_LATENCY == 1, where the result is written
   // on the accept edge itself.
   always_comb begin
      prod_mag    = {{WIDTH{1'b0}}, quo_q}   * {{WIDTH{1'b0}}, dvs_q};
      prod        = neg_q ? -prod_mag : prod_mag;
      in_prod_mag = {{WIDTH{1'b0}}, in_mag1} * {{WIDTH{1'b0}}, in_mag2};
      in_prod     = in_neg ? -in_prod_mag : in_prod_mag;
   end

   // One restoring-division step: shift in the next dividend bit, then
   // subtract the divisor if it fits. When the subtraction succeeds, the
   // remainder is below the divisor, so the low WIDTH bits of the difference
   // are exact.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      diff    = shifted[WIDTH-1:0] - dvs_q;
      it_rem  = ge ? diff : shifted[WIDTH-1:0];
      it_quo  = {quo_q[WIDTH-2:0], ge};
   end

   // Sign correction for the final division step. The corrected value is
   // registered into result on the edge that enters FIX. A zero divisor
   // bypasses the correction and returns the raw dividend in the high half.
   always_comb begin
      q_fix   = neg_q  ? -it_quo : it_quo;
      r_fix   = rneg_q ? -it_rem : it_rem;
      div_res = dz_q ? {op1_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // FSM next state and result-write control.
   // FIX is the done cycle of a divide. It is not busy and can accept like IDLE.
   always_comb begin
      state_n = state;
      wr_res  = 1'b0;
      res_n   = '0;
      case (state)
         S_IDLE, S_FIX: begin
            state_n = S_IDLE;
            if (accept) begin
               if (!op[1]) begin
                  if (MULT_LATENCY == 1) begin
                     wr_res = 1'b1;
                     res_n  = in_prod;
                  end else begin
                     state_n = S_MUL;
                  end
               end else begin
`ifdef MDU_DIVZERO_FAST_EN
                  if (operand_2 == '0) begin
                     state_n = S_FIX;
                     wr_res  = 1'b1;
                     res_n   = {operand_1, {WIDTH{1'b1}}};
                  end else begin
                     state_n = S_DIV;
                  end
`else
                  state_n = S_DIV;
`endif
               end
            end
         end
         S_MUL: begin
            if (cnt == MUL_LAST) begin
               state_n = S_IDLE;
               wr_res  = 1'b1;
               res_n   = prod;
            end
         end
         S_DIV: begin
            if (cnt == DIV_LAST) begin
               state_n = S_FIX;
               wr_res  = 1'b1;
               res_n   = div_res;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      // An abort discards any completion that would land on this edge.
      if (flush) begin
         state_n = S_IDLE;
         wr_res  = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         op1_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= wr_res;
         if (wr_res) begin
            result_q <= res_n;
         end
         if (accept) begin
            cnt    <= '0;
            quo_q  <= in_mag1;
            dvs_q  <= in_mag2;
            rem_q  <= '0;
            op1_q  <= operand_1;
            neg_q  <= in_neg;
            rneg_q <= in_sgn && operand_1[WIDTH-1];
            dz_q   <= (operand_2 == '0);
         end else if (state == S_DIV) begin
            rem_q <= it_rem;
            quo_q <= it_quo;
            cnt   <= cnt + CW'(1);
         end else if (state == S_MUL) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Scoreboard bench for mult_div_unit (WIDTH=32, MULT_LATENCY=2).
//   The driver pushes the expected result and the expected done cycle when it
//   issues a request. A separate monitor pops and compares on every done.
//   The expected values come from wide-integer arithmetic in model(), or from
//   literal constants in the directed cases.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int W = 32;
   localparam int L = 2;

   // Clock and reset
   logic            clk   = 1'b0;
   logic            rst   = 1'b0;
   logic            flush = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      op    = 2'b00;
   logic [W-1:0]    a     = '0;
   logic [W-1:0]    b     = '0;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  result;
   logic [1:0]      dbg_state;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W), .MULT_LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .start     (start),
      .op        (op),
      .operand_1 (a),
      .operand_2 (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   int ecount = 0;
   always @(posedge clk) ecount++;

   // Scoreboard state
   logic [2*W-1:0]  exp_q[$];
   int              exp_t_q[$];
   logic [2*W-1:0]  last_res = '0;
   logic [2*W-1:0]  mon_e;
   int              mon_t;
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, sq, sr;
      logic [63:0] ux, uy, r64, q64;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      case (o)
         2'b00: model = 64'(sx * sy);
         2'b01: model = ux * uy;
         default: begin
            if (y == 32'h0) begin
               model = {x, 32'hFFFFFFFF};
            end else if (o == 2'b10) begin
               sq  = sx / sy;
               sr  = sx % sy;
               q64 = 64'(sq);
               r64 = 64'(sr);
               model = {r64[31:0], q64[31:0]};
            end else begin
               q64 = ux / uy;
               r64 = ux % uy;
               model = {r64[31:0], q64[31:0]};
            end
         end
      endcase
   endfunction

   // Edges from accept to the edge that raises done
   function automatic int lat(input logic [1:0] o, input logic [31:0] y);
      if (!o[1]) return L - 1;
`ifdef MDU_DIVZERO_FAST_EN
      if (y == 32'h0) return 0;
`else
      if (y == 32'h0) return W;
`endif
      return W;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       pick = 32'h0;
         1:       pick = 32'h1;
         2:       pick = 32'hFFFFFFFF;
         3:       pick = 32'h80000000;
         4:       pick = 32'h7FFFFFFF;
         5:       pick = 32'($urandom_range(0, 15));
         default: pick = $urandom;
      endcase
   endfunction

   // Monitor: compares each done against the head of the expected queue
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 result=%h required no pending op (t=%0t)", result, $time);
         end else begin
            mon_e = exp_q.pop_front();
            mon_t = exp_t_q.pop_front();
            check("result", result, mon_e);
            check("done_cycle", 64'(ecount), 64'(mon_t));
            check("busy_at_done", {63'h0, busy}, 64'h0);
            last_res = mon_e;
         end
      end
   end

   // Driver tasks. All input changes happen 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] e);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(e);
      exp_t_q.push_back(ecount + 1 + lat(o, y));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         tick();
         k++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got %0d pending ops required 0", exp_q.size());
         exp_q.delete();
         exp_t_q.delete();
      end
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog");
   end

   logic [1:0]  r_op;
   logic [31:0] r_x, r_y;

   initial begin
      // Reset values
      rst = 1'b0;
      repeat (3) tick();
      check("reset_busy",   {63'h0, busy}, 64'h0);
      check("reset_done",   {63'h0, done}, 64'h0);
      check("reset_result", result, 64'h0);
      check("reset_state",  {62'h0, dbg_state}, 64'h0);
      rst = 1'b1;
      tick();

      // Directed cases with literal expected values
      issue(2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
      check("mult_busy_t1", {63'h0, busy}, 64'h1);
      wait_idle();
      issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
      wait_idle();
      issue(2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
      wait_idle();
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
      wait_idle();
      issue(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
      wait_idle();
      issue(2'b11, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF});
      wait_idle();
      issue(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
      wait_idle();
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      wait_idle();
      issue(2'b10, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
      wait_idle();

      // start while busy is ignored
      issue(2'b11, 32'd1000, 32'd3, {32'd1, 32'd333});
      repeat (3) tick();
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_ignores_start", {63'h0, busy}, 64'h1);
      wait_idle();

      // start and flush together: flush wins
      op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      check("start_flush_busy", {63'h0, busy}, 64'h0);
      repeat (4) tick();
      check("start_flush_result", result, last_res);

      // Flush mid-divide at T+10, then a new MULTU at T+11
      issue(2'b11, 32'd1000, 32'd7, {32'd6, 32'd142});
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      void'(exp_q.pop_back());
      void'(exp_t_q.pop_back());
      check("flush_busy", {63'h0, busy}, 64'h0);
      check("flush_result_held", result, last_res);
      issue(2'b01, 32'd3, 32'd4, {32'h0, 32'd12});
      wait_idle();
      repeat (25) tick();

      // Reset mid-divide at T+5
      issue(2'b10, 32'd1000, 32'd3, {32'd1, 32'd333});
      repeat (4) tick();
      #2;
      rst = 1'b0;
      #1;
      check("arst_busy",   {63'h0, busy}, 64'h0);
      check("arst_done",   {63'h0, done}, 64'h0);
      check("arst_result", result, 64'h0);
      exp_q.delete();
      exp_t_q.delete();
      last_res = '0;
      repeat (3) tick();
      op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
      tick();
      check("start_in_reset", {63'h0, busy}, 64'h0);
      tick();
      start = 1'b0;
      rst   = 1'b1;
      tick();
      check("after_reset_busy", {63'h0, busy}, 64'h0);

      // Randomised operations against the model
      for (int i = 0; i < 60; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_x  = pick();
         r_y  = pick();
         issue(r_op, r_x, r_y, model(r_op, r_x, r_y));
         wait_idle();
      end

      repeat (5) tick();
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
